// File: rtl/uart_hex_tx.sv
// Serial hex dumper: sends a 32-bit word as 8 uppercase ASCII hex digits plus CR LF,
// using 8N1 framing at CLKS_PER_BIT clocks per bit.
module uart_hex_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        CLK100MHZ,
  input  logic        rst_n,
  input  logic        send,
  input  logic [31:0] word,
  output logic        busy,
  output logic        done,
  output logic        rs232_tx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  state_reg;
  logic [15:0] baud_cnt_reg;
  logic [2:0]  bit_idx_reg;
  logic [3:0]  char_idx_reg;
  logic [31:0] shift_reg;
  logic        tx_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [7:0]  cur_char;

  // 'A' - 10 = 0x37, so letters come out uppercase only
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // The top nibble of the shift register is always the current digit
  always_comb begin
    cur_char = hex_ascii(shift_reg[31:28]);
    if (char_idx_reg == 4'd8)
      cur_char = 8'h0D;
    else if (char_idx_reg == 4'd9)
      cur_char = 8'h0A;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= 16'd0;
      bit_idx_reg  <= 3'd0;
      char_idx_reg <= 4'd0;
      shift_reg    <= 32'd0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == S_IDLE) begin
        if (send && !busy_reg) begin
          shift_reg    <= word;
          char_idx_reg <= 4'd0;
          bit_idx_reg  <= 3'd0;
          baud_cnt_reg <= 16'd0;
          state_reg    <= S_START;
          tx_reg       <= 1'b0;
          busy_reg     <= 1'b1;
        end
      end else if (baud_cnt_reg != BAUD_LAST) begin
        baud_cnt_reg <= baud_cnt_reg + 16'd1;
      end else begin
        // Bit boundary: the line value for the next bit is registered here
        baud_cnt_reg <= 16'd0;
        case (state_reg)
          S_START: begin
            state_reg   <= S_DATA;
            bit_idx_reg <= 3'd0;
            tx_reg      <= cur_char[0];
          end
          S_DATA: begin
            if (bit_idx_reg == 3'd7) begin
              state_reg <= S_STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= cur_char[bit_idx_reg + 3'd1];
            end
          end
          S_STOP: begin
            if (char_idx_reg != 4'd9) begin
              char_idx_reg <= char_idx_reg + 4'd1;
              shift_reg    <= {shift_reg[27:0], 4'h0};
              state_reg    <= S_START;
              tx_reg       <= 1'b0;
            end else begin
              state_reg <= S_IDLE;
              tx_reg    <= 1'b1;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
          default: begin
            state_reg <= S_IDLE;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rs232_tx = tx_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule
